muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, sitting in EX beside `ALU` and fed the same A/B operands from register read. It implements mult, multu, div, divu, mthi and mtlo. Multi-cycle ops are started with a one-cycle `start` strobe; the stall controller holds the pipeline while `busy` is high. HI/LO feed the mfhi/mflo path into the writeback mux.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `A`  in  32: operand rs (dividend / multiplicand / mthi/mtlo source).
- `B`  in  32: operand rt (divisor / multiplier).
- `MDctr`  in  3: op code. 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
- `start`  in  1: op request strobe, sampled at the rising edge.
- `busy`  out  1: multi-cycle op in progress.
- `done`  out  1: one-cycle pulse when HI/LO have just been updated.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE, `start`=1, MDctr ∈ {001..100}: latch |A|/|B| (signed ops) or A/B (unsigned ops), the result sign flags and the op. Counter = 0. Go to CALC.
  - IDLE, `start`=1, MDctr=101/110: write `hi`=A or `lo`=A at that edge. Stay in IDLE. No `busy`, no `done`.
  - IDLE, `start`=1, MDctr=000/111: ignored.
- CALC: one radix-2 step per cycle, 32 steps.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract. Remainder is 33-bit internally.
  - After step 32, go to FIX.
- FIX, one cycle: apply sign correction, write `hi`/`lo`, pulse `done`, return to IDLE.
- Signed rules:
  - Product negative iff A[31]^B[31].
  - Quotient negative iff A[31]^B[31].
  - Remainder takes the sign of A.
- Multiply result: `hi` = product[63:32], `lo` = product[31:0].
- Divide result: `lo` = quotient, `hi` = remainder.
- Divide by zero (div or divu): `hi` = A, `lo` = 32'hFFFF_FFFF. No exception.
- div 32'h8000_0000 / 32'hFFFF_FFFF: `lo` = 32'h8000_0000, `hi` = 0.
- Operands are captured at start. A and B may change during CALC without effect.
- `start` while `busy`: ignored, and no queueing.
- Reset, including mid-operation: state IDLE, counter 0, `hi` = `lo` = 0, `busy` = 0, `done` = 0. The aborted op never produces `done`.

## Timing
- Accept edge E0: `busy` = 1 from after E0.
- CALC edges: E1..E32.
- FIX edge E33: `hi`/`lo` updated, `done` = 1 and `busy` = 0 for the cycle after E33.
- A new `start` is accepted at E34 at the earliest, i.e. back-to-back in the `done` cycle.
- Total latency from start to result: 33 cycles for every multi-cycle op. There is no early termination.
- mthi/mtlo: the value is visible on `hi`/`lo` in the cycle after the accept edge.
- `hi`/`lo` are registered outputs and never change in any cycle other than those above.
- `busy` and `done` are registered. `done` and `busy` are never high together.

## Configuration
- `MULDIV_DIV_EN` defined: div and divu are supported as described above.
- `MULDIV_DIV_EN` undefined:
  - Divider datapath removed. MDctr 011/100 are treated as none: ignored, no `busy`, HI/LO unchanged.
  - Multiply, mthi and mtlo are unaffected, including identical latency.

## Structure
- Shared package `cpu_pkg`:
  - MDctr encodings as named constants/enum `md_op_t`.
  - `MD_ITERS` = 32.
  - FSM state type.
- One natural sub-module, `md_sign_fix`: combinational conditional two's-complement.
  - Used for operand absolute value at accept.
  - Used for product/quotient/remainder negation in FIX.
- The FSM, counter and 64-bit shift datapath stay in `muldiv_unit`.

## Test plan
- mult A=32'hFFFF_FFFE, B=3:
  - `busy` high exactly 33 cycles.
  - Then `hi`=32'hFFFF_FFFF, `lo`=32'hFFFF_FFFA, with a single `done` pulse.
- multu A=32'hFFFF_FFFE, B=3 → `hi`=32'h0000_0002, `lo`=32'hFFFF_FFFA.
- div A=32'hFFFF_FFF9 (-7), B=2 → `lo`=32'hFFFF_FFFD, `hi`=32'hFFFF_FFFF.
- Corner-case divides:
  - divu A=7, B=0 → `hi`=7, `lo`=32'hFFFF_FFFF.
  - div 32'h8000_0000 / 32'hFFFF_FFFF → `lo`=32'h8000_0000, `hi`=0.
- mthi A=32'h1234_5678 → `hi`=32'h1234_5678 next cycle, `busy` never asserted. Then mtlo 32'hDEAD_BEEF the next cycle → `lo` updated, `hi` retained.
- Abort and ignored start:
  - mult started, `start` with divu re-asserted at cycle 5 → ignored, and the mult result is correct.
  - Second mult, `rst_n` low at cycle 10 → `busy`=0, `hi`=`lo`=0, and no `done` afterwards.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   md_op_t    : MDctr encodings as driven by the decoder.
//   md_state_t : state type of the muldiv_unit sequencer.
//   MD_ITERS   : number of radix-2 iterations per multi-cycle op.
//   MD_CNT_W   : width of the iteration counter.
// Optional feature macro used by the unit: MULDIV_DIV_EN (divider present).
package cpu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_NONE7 = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = $clog2(MD_ITERS);

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement: res = neg ? -val : val.
// Ports:
//   neg : negate request
//   val : input value (W bits)
//   res : conditionally negated value (W bits)
// Used both for operand absolute values and for result sign correction.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] val,
  output logic [W-1:0] res
);

  always_comb begin
    res = val;
    if (neg) res = ~val + W'(1);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   A, B            : rs / rt operands from register read
//   MDctr, start    : op code and one-cycle request strobe
//   busy, done      : multi-cycle op in progress / HI-LO just written
//   hi, lo          : HI and LO registers
// Configuration macro: MULDIV_DIV_EN. When undefined the divider datapath is
// absent and div/divu are ignored like MDctr=000.
// Handshake: start is sampled at a rising edge only while busy is low; a
// multi-cycle op holds busy for 33 cycles, then done pulses for exactly one
// cycle with busy low, and a new start is accepted in that done cycle.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDctr,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]           acc_q, acc_d;     // {high/remainder, low/quotient}
  logic [31:0]           opnd_q, opnd_d;   // multiplicand or divisor
  logic                  neg_q, neg_d;     // product/quotient negative
  logic [31:0]           hi_q, hi_d, lo_q, lo_d;
  logic                  busy_q, busy_d, done_q, done_d;

  md_op_t      op;
  logic        is_signed, is_mul_op;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, prod_fix;

  assign op        = md_op_t'(MDctr);
  assign is_mul_op = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MULDIV_DIV_EN
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
`else
  assign is_signed = (op == MD_MULT);
`endif

  md_sign_fix #(.W(32)) u_abs_a (.neg(is_signed & A[31]), .val(A), .res(abs_a));
  md_sign_fix #(.W(32)) u_abs_b (.neg(is_signed & B[31]), .val(B), .res(abs_b));
  md_sign_fix #(.W(64)) u_prod  (.neg(neg_q), .val(acc_q), .res(prod_fix));

  // Shift-add: the multiplier sits in the low half and is consumed LSB first
  // while the partial product enters from the top.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

`ifdef MULDIV_DIV_EN
  logic        is_div_q, is_div_d;
  logic        rneg_q, rneg_d;   // remainder takes the sign of A
  logic        dz_q, dz_d;       // divide by zero
  logic [32:0] rem33;
  logic        rem_ge;
  logic [31:0] rem_sub, rem_new, quo_fix, rem_fix;
  logic [63:0] div_next;

  // Restoring step. The running remainder is always below the divisor, so
  // the 32-bit difference is exact whenever the subtraction is taken.
  assign rem33    = {acc_q[63:32], acc_q[31]};
  assign rem_ge   = rem33 >= {1'b0, opnd_q};
  assign rem_sub  = rem33[31:0] - opnd_q;
  assign rem_new  = rem_ge ? rem_sub : rem33[31:0];
  assign div_next = {rem_new, acc_q[30:0], rem_ge};

  md_sign_fix #(.W(32)) u_quo (.neg(neg_q),  .val(acc_q[31:0]),  .res(quo_fix));
  md_sign_fix #(.W(32)) u_rem (.neg(rneg_q), .val(acc_q[63:32]), .res(rem_fix));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul_op) begin
            state_d = ST_CALC;
            cnt_d   = '0;
            busy_d  = 1'b1;
            acc_d   = {32'd0, abs_b};
            opnd_d  = abs_a;
            neg_d   = is_signed & (A[31] ^ B[31]);
`ifdef MULDIV_DIV_EN
            is_div_d = 1'b0;
          end else if ((op == MD_DIV) || (op == MD_DIVU)) begin
            state_d  = ST_CALC;
            cnt_d    = '0;
            busy_d   = 1'b1;
            acc_d    = {32'd0, abs_a};
            opnd_d   = abs_b;
            neg_d    = is_signed & (A[31] ^ B[31]);
            is_div_d = 1'b1;
            rneg_d   = is_signed & A[31];
            dz_d     = (B == 32'd0);
`endif
          end else if (op == MD_MTHI) begin
            hi_d = A;
          end else if (op == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_CALC: begin
`ifdef MULDIV_DIV_EN
        acc_d = is_div_q ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MD_CNT_W'(MD_ITERS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        {hi_d, lo_d} = prod_fix;
`ifdef MULDIV_DIV_EN
        // Divide by zero leaves |A| as remainder; its sign fix restores A.
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = dz_q ? 32'hFFFF_FFFF : quo_fix;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
